// File: rtl/board_io_ctrl.sv
// board_io_ctrl: board-level I/O front end.
// The front end synchronizes and debounces the push buttons and slide switches.
// It produces one-cycle press and release pulses for each key.
// It drives the seven-segment digits and the LEDs from registers.
// A shared blink phase gates any digit or LED that has its blink enable set.

module board_io_ctrl #(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 10,
    parameter int NUM_HEX         = 6,
    parameter int NUM_LED         = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NUM_KEYS-1:0]    i_key,
    input  logic [NUM_SW-1:0]      i_switch,
    input  logic [4*NUM_HEX-1:0]   i_hex_value,
    input  logic [NUM_HEX-1:0]     i_hex_enable,
    input  logic [NUM_HEX-1:0]     i_hex_blink,
    input  logic [NUM_LED-1:0]     i_led,
    input  logic [NUM_LED-1:0]     i_led_blink,
    output logic [NUM_KEYS-1:0]    o_key_level,
    output logic [NUM_KEYS-1:0]    o_key_press,
    output logic [NUM_KEYS-1:0]    o_key_release,
    output logic [NUM_SW-1:0]      o_switch,
    output logic [7*NUM_HEX-1:0]   o_hex,
    output logic [NUM_LED-1:0]     o_led,
    output logic                   o_blink_phase
);

    // The debounce counter only ever reaches DEBOUNCE_CYCLES-1 and then clears.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The blink counter runs 0..BLINK_CYCLES-1 and then wraps.
    localparam int BLINK_W = $clog2(BLINK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [NUM_KEYS-1:0] key_meta;
    logic [NUM_KEYS-1:0] key_sync;
    logic [NUM_KEYS-1:0] key_stable;
    logic [CNT_W-1:0]    key_cnt [NUM_KEYS];

    logic [NUM_SW-1:0]   sw_meta;
    logic [NUM_SW-1:0]   sw_sync;
    logic [NUM_SW-1:0]   sw_stable;
    logic [CNT_W-1:0]    sw_cnt [NUM_SW];

    logic [BLINK_W-1:0]  blink_cnt;

    logic [7*NUM_HEX-1:0] hex_next;
    logic [NUM_LED-1:0]   led_next;

    // Standard active-low hex glyphs. The bit order is {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Two-flop synchronizers. Reset parks keys as released (1) and switches as 0.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            key_meta <= '1;
            key_sync <= '1;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= i_key;
            key_sync <= key_meta;
            sw_meta  <= i_switch;
            sw_sync  <= sw_meta;
        end
    end

    // Key debounce. A key is accepted after DEBOUNCE_CYCLES consecutive mismatching cycles.
    // A press or release pulse is issued exactly when the stable value flips.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            key_stable    <= '1;
            o_key_press   <= '0;
            o_key_release <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                key_cnt[k] <= '0;
            end
        end else begin
            o_key_press   <= '0;
            o_key_release <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (key_sync[k] == key_stable[k]) begin
                    key_cnt[k] <= '0;
                end else if (key_cnt[k] == DEB_LAST) begin
                    key_stable[k]    <= key_sync[k];
                    key_cnt[k]       <= '0;
                    o_key_press[k]   <= ~key_sync[k];
                    o_key_release[k] <= key_sync[k];
                end else begin
                    key_cnt[k] <= key_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Switch debounce uses the same qualification rule but issues no edge pulses.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sw_stable <= '0;
            for (int s = 0; s < NUM_SW; s++) begin
                sw_cnt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SW; s++) begin
                if (sw_sync[s] == sw_stable[s]) begin
                    sw_cnt[s] <= '0;
                end else if (sw_cnt[s] == DEB_LAST) begin
                    sw_stable[s] <= sw_sync[s];
                    sw_cnt[s]    <= '0;
                end else begin
                    sw_cnt[s] <= sw_cnt[s] + 1'b1;
                end
            end
        end
    end

    // Buttons are active-low, so the reported level is the inverse of the stable value.
    assign o_key_level = ~key_stable;
    assign o_switch    = sw_stable;

    // Free-running blink timebase. The phase flips each time the counter wraps.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            blink_cnt     <= '0;
            o_blink_phase <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt     <= '0;
            o_blink_phase <= ~o_blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Next display and LED values. A digit is blanked when it is disabled.
    // A digit is also blanked while its blink is on during the off phase.
    always_comb begin
        hex_next = '1;
        led_next = '0;
        for (int d = 0; d < NUM_HEX; d++) begin
            if (!i_hex_enable[d] || (i_hex_blink[d] && !o_blink_phase)) begin
                hex_next[7*d +: 7] = 7'h7F;
            end else begin
                hex_next[7*d +: 7] = hex_glyph(i_hex_value[4*d +: 4]);
            end
        end
        for (int i = 0; i < NUM_LED; i++) begin
            led_next[i] = i_led[i] & ~(i_led_blink[i] & ~o_blink_phase);
        end
    end

    // Register the display and LEDs. They lag their inputs and the phase by one cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_hex <= '1;
            o_led <= '0;
        end else begin
            o_hex <= hex_next;
            o_led <= led_next;
        end
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: self-checking bench for board_io_ctrl.
// The bench uses a fast debounce time (4 cycles) and a fast blink time (8 cycles).
// It runs directed scenarios first, then randomized stimulus.
// Every cycle it compares the DUT against a reference model.
// The model uses a sliding window over the history of sampled inputs.

module tb_board_io_ctrl;

    localparam int NUM_KEYS = 4;
    localparam int NUM_SW   = 10;
    localparam int NUM_HEX  = 6;
    localparam int NUM_LED  = 10;
    localparam int DEB      = 4;
    localparam int BLINK    = 8;
    localparam int HIST     = 8192;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_KEYS-1:0]   key_v;
    logic [NUM_SW-1:0]     sw_v;
    logic [4*NUM_HEX-1:0]  hex_val_v;
    logic [NUM_HEX-1:0]    hex_en_v;
    logic [NUM_HEX-1:0]    hex_bl_v;
    logic [NUM_LED-1:0]    led_v;
    logic [NUM_LED-1:0]    led_bl_v;

    logic [NUM_KEYS-1:0]   o_key_level;
    logic [NUM_KEYS-1:0]   o_key_press;
    logic [NUM_KEYS-1:0]   o_key_release;
    logic [NUM_SW-1:0]     o_switch;
    logic [7*NUM_HEX-1:0]  o_hex;
    logic [NUM_LED-1:0]    o_led;
    logic                  o_blink_phase;

    int check_count = 0;
    int error_count = 0;

    // Reference model state
    logic [NUM_KEYS-1:0]   key_hist [0:HIST-1];
    logic [NUM_SW-1:0]     sw_hist  [0:HIST-1];
    int                    edge_num;
    int                    blink_edges;
    logic [NUM_KEYS-1:0]   m_key_stable;
    logic [NUM_SW-1:0]     m_sw_stable;
    logic [NUM_KEYS-1:0]   m_level;
    logic [NUM_KEYS-1:0]   m_press;
    logic [NUM_KEYS-1:0]   m_release;
    logic [7*NUM_HEX-1:0]  m_hex;
    logic [NUM_LED-1:0]    m_led;
    logic                  m_phase;
    logic [6:0]            glyph [0:15];

    logic [7*NUM_HEX-1:0]  all_blank;
    int                    acc;
    int                    on_led;
    int                    on_dig;

    always #5 clock = ~clock;

    board_io_ctrl #(
        .NUM_KEYS(NUM_KEYS), .NUM_SW(NUM_SW), .NUM_HEX(NUM_HEX), .NUM_LED(NUM_LED),
        .DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLINK)
    ) dut (
        .i_clock(clock),
        .i_reset(reset),
        .i_key(key_v),
        .i_switch(sw_v),
        .i_hex_value(hex_val_v),
        .i_hex_enable(hex_en_v),
        .i_hex_blink(hex_bl_v),
        .i_led(led_v),
        .i_led_blink(led_bl_v),
        .o_key_level(o_key_level),
        .o_key_press(o_key_press),
        .o_key_release(o_key_release),
        .o_switch(o_switch),
        .o_hex(o_hex),
        .o_led(o_led),
        .o_blink_phase(o_blink_phase)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, actual, expected, edge_num);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_KEYS-1:0] k, input logic [NUM_SW-1:0] s,
                                 input logic [4*NUM_HEX-1:0] hv, input logic [NUM_HEX-1:0] he,
                                 input logic [NUM_HEX-1:0] hb, input logic [NUM_LED-1:0] l,
                                 input logic [NUM_LED-1:0] lb);
        key_v     = k;
        sw_v      = s;
        hex_val_v = hv;
        hex_en_v  = he;
        hex_bl_v  = hb;
        led_v     = l;
        led_bl_v  = lb;
    endtask

    // A level is accepted once the synchronized sample has disagreed with it for DEB consecutive edges.
    // The synchronized sample at edge n is the raw value sampled at edge n-2.
    function automatic bit keyQualifies(int k);
        for (int j = 0; j < DEB; j++) begin
            if (key_hist[edge_num-2-j][k] == m_key_stable[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit swQualifies(int s);
        for (int j = 0; j < DEB; j++) begin
            if (sw_hist[edge_num-2-j][s] == m_sw_stable[s]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Advance the model by one rising edge, using the inputs present on the pins.
    task automatic modelEdge();
        bit pb;
        edge_num++;
        if (reset) begin
            key_hist[edge_num]   = '1;
            key_hist[edge_num-1] = '1;
            sw_hist[edge_num]    = '0;
            sw_hist[edge_num-1]  = '0;
            m_key_stable = '1;
            m_sw_stable  = '0;
            m_press      = '0;
            m_release    = '0;
            m_hex        = all_blank;
            m_led        = '0;
            blink_edges  = 0;
            m_phase      = 1'b1;
        end else begin
            key_hist[edge_num] = key_v;
            sw_hist[edge_num]  = sw_v;
            m_press   = '0;
            m_release = '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (keyQualifies(k)) begin
                    m_key_stable[k] = ~m_key_stable[k];
                    if (m_key_stable[k] == 1'b0) m_press[k] = 1'b1;
                    else                         m_release[k] = 1'b1;
                end
            end
            for (int s = 0; s < NUM_SW; s++) begin
                if (swQualifies(s)) m_sw_stable[s] = ~m_sw_stable[s];
            end
            pb = ((blink_edges / BLINK) % 2) == 0;
            for (int d = 0; d < NUM_HEX; d++) begin
                if (!hex_en_v[d] || (hex_bl_v[d] && !pb)) m_hex[7*d +: 7] = 7'h7F;
                else m_hex[7*d +: 7] = glyph[hex_val_v[4*d +: 4]];
            end
            for (int i = 0; i < NUM_LED; i++) begin
                m_led[i] = (led_bl_v[i] && !pb) ? 1'b0 : led_v[i];
            end
            blink_edges++;
            m_phase = ((blink_edges / BLINK) % 2) == 0;
        end
        m_level = ~m_key_stable;
    endtask

    task automatic compareAll();
        checkOutput("level",   o_key_level,   m_level);
        checkOutput("press",   o_key_press,   m_press);
        checkOutput("release", o_key_release, m_release);
        checkOutput("switch",  o_switch,      m_sw_stable);
        checkOutput("hex",     o_hex,         m_hex);
        checkOutput("led",     o_led,         m_led);
        checkOutput("phase",   o_blink_phase, m_phase);
    endtask

    // Each cycle has one rising edge, then model update, then a comparison on the falling edge.
    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            modelEdge();
            @(negedge clock);
            compareAll();
        end
    endtask

    initial begin
        all_blank = '1;
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < HIST; i++) begin
            key_hist[i] = '1;
            sw_hist[i]  = '0;
        end
        edge_num     = 8;
        blink_edges  = 0;
        m_key_stable = '1;
        m_sw_stable  = '0;
        m_level      = '0;
        m_press      = '0;
        m_release    = '0;
        m_hex        = all_blank;
        m_led        = '0;
        m_phase      = 1'b1;

        // Hold reset for 3 cycles with idle inputs. All outputs must stay at their reset values.
        applyStimulus('1, '0, '0, '0, '0, '0, '0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            runCycles(1);
            checkOutput("rst_level",   o_key_level,   4'h0);
            checkOutput("rst_press",   o_key_press,   4'h0);
            checkOutput("rst_release", o_key_release, 4'h0);
            checkOutput("rst_switch",  o_switch,      10'h0);
            checkOutput("rst_hex",     o_hex,         all_blank);
            checkOutput("rst_led",     o_led,         10'h0);
            checkOutput("rst_phase",   o_blink_phase, 1'b1);
        end
        reset = 1'b0;
        runCycles(10);

        // Press key 1 and hold it. The level must rise 6 edges later with a single press pulse.
        key_v[1] = 1'b0;
        runCycles(5);
        checkOutput("k1_level_early", o_key_level[1], 1'b0);
        runCycles(1);
        checkOutput("k1_level_on", o_key_level[1], 1'b1);
        checkOutput("k1_press",    o_key_press[1], 1'b1);
        runCycles(1);
        checkOutput("k1_press_once", o_key_press[1], 1'b0);
        key_v[1] = 1'b1;
        runCycles(5);
        checkOutput("k1_rel_early", o_key_release[1], 1'b0);
        runCycles(1);
        checkOutput("k1_release",   o_key_release[1], 1'b1);
        checkOutput("k1_level_off", o_key_level[1],   1'b0);
        runCycles(1);
        checkOutput("k1_rel_once", o_key_release[1], 1'b0);

        // A 3-cycle glitch on key 0 must be rejected.
        acc = 0;
        key_v[0] = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) key_v[0] = 1'b1;
            runCycles(1);
            acc += int'(o_key_level[0]) + int'(o_key_press[0]) + int'(o_key_release[0]);
        end
        checkOutput("k0_glitch", acc, 0);

        // A 5-cycle pulse on switch 9 must be accepted.
        acc = 0;
        sw_v[9] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 5) sw_v[9] = 1'b0;
            runCycles(1);
            acc += int'(o_switch[9]);
        end
        checkOutput("sw9_seen", acc > 0, 1'b1);

        // Hex glyphs: one-cycle latency, blanking on enable.
        hex_val_v = 24'h00F_00A;
        hex_val_v[7:4] = 4'h0;
        hex_en_v = 6'b001011;
        runCycles(1);
        checkOutput("hex_A",  o_hex[6:0],   7'b0001000);
        checkOutput("hex_0",  o_hex[13:7],  7'b1000000);
        checkOutput("hex_F",  o_hex[27:21], 7'b0001110);
        checkOutput("hex_off", o_hex[20:14], 7'h7F);
        hex_en_v[0] = 1'b0;
        runCycles(1);
        checkOutput("hex_dis", o_hex[6:0], 7'h7F);

        // Blink: digit 2 and LED 0 must each be on for half of any 32-cycle window.
        hex_val_v[11:8] = 4'h8;
        hex_en_v = '1;
        hex_bl_v = 6'b000100;
        led_v = 10'h001;
        led_bl_v = 10'h001;
        runCycles(2);
        on_led = 0;
        on_dig = 0;
        for (int i = 0; i < 4 * BLINK; i++) begin
            runCycles(1);
            on_led += int'(o_led[0]);
            on_dig += (o_hex[20:14] != 7'h7F) ? 1 : 0;
        end
        checkOutput("led0_on", on_led, 2 * BLINK);
        checkOutput("dig2_on", on_dig, 2 * BLINK);

        // A reset during qualification discards the edge. The key is qualified again after reset.
        key_v[2] = 1'b0;
        runCycles(2);
        reset = 1'b1;
        runCycles(2);
        reset = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            runCycles(1);
            acc += int'(o_key_press[2]) + int'(o_key_level[2]);
        end
        checkOutput("k2_no_early", acc, 0);
        runCycles(1);
        checkOutput("k2_requal_lvl", o_key_level[2], 1'b1);
        checkOutput("k2_requal_prs", o_key_press[2], 1'b1);
        key_v[2] = 1'b1;
        runCycles(8);

        // Randomized traffic with bounces, mixed-key edges and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 399) == 0) reset = 1'b1;
            if ($urandom_range(0, 5) == 0) key_v[$urandom_range(0, NUM_KEYS-1)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) sw_v[$urandom_range(0, NUM_SW-1)] ^= 1'b1;
            hex_val_v = {$urandom, $urandom} & {4*NUM_HEX{1'b1}};
            hex_en_v  = NUM_HEX'($urandom);
            hex_bl_v  = NUM_HEX'($urandom);
            led_v     = NUM_LED'($urandom);
            led_bl_v  = NUM_LED'($urandom);
            runCycles(1);
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
